// File: rtl/dds_adc_pkg.sv
// rtl/dds_adc_pkg.sv - shared types and defaults for the DDS x ADC I/Q scheduler
package dds_adc_pkg;
   localparam int MUL_LAT = 3;
   localparam int ACC_W   = 48;
   localparam int LEN_W   = 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic vld;
      logic is_q;
   } tag_t;
endpackage

// File: rtl/dds_adc_iq_sched_if.sv
// rtl/dds_adc_iq_sched_if.sv - control, sample, multiplier and result bundle of the I/Q scheduler
interface dds_adc_iq_sched_if #(
   parameter int ACC_W = dds_adc_pkg::ACC_W,
   parameter int LEN_W = dds_adc_pkg::LEN_W
);
   logic                    start;
   logic                    abort;
   logic        [LEN_W-1:0] acc_len;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [31:0]      dds_sin;
   logic signed [31:0]      dds_cos;
   logic signed [11:0]      adc;
   logic signed [31:0]      mul_a;
   logic signed [11:0]      mul_y;
   logic signed [31:0]      mul_p;
   logic                    busy;
   logic                    out_valid;
   logic signed [ACC_W-1:0] i_sum;
   logic signed [ACC_W-1:0] q_sum;
   logic                    ovf;

   modport master (
      output start, abort, acc_len, in_valid, dds_sin, dds_cos, adc, mul_p,
      input  in_ready, mul_a, mul_y, busy, out_valid, i_sum, q_sum, ovf
   );

   modport slave (
      input  start, abort, acc_len, in_valid, dds_sin, dds_cos, adc, mul_p,
      output in_ready, mul_a, mul_y, busy, out_valid, i_sum, q_sum, ovf
   );
endinterface

// File: rtl/sat_acc.sv
// rtl/sat_acc.sv - signed saturating accumulator with sticky saturation flag
module sat_acc #(
   parameter int W = 48
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] acc,
   output logic                sat
);
   logic [W:0] sum;

   // One guard bit: overflow whenever the guard and sign bits disagree
   always_comb sum = {acc[W-1], acc} + {din[W-1], din};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (en) begin
         if (sum[W] != sum[W-1]) begin
            acc <= sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            sat <= 1'b1;
         end else begin
            acc <= sum[W-1:0];
         end
      end
   end
endmodule

// File: rtl/dds_adc_iq_sched.sv
// rtl/dds_adc_iq_sched.sv - shares one 32x12 multiplier between sin*adc and cos*adc, accumulates I/Q sums
module dds_adc_iq_sched #(
   parameter int MUL_LAT = dds_adc_pkg::MUL_LAT,
   parameter int ACC_W   = dds_adc_pkg::ACC_W,
   parameter int LEN_W   = dds_adc_pkg::LEN_W
) (
   input logic              clk,
   input logic              rst,
   dds_adc_iq_sched_if.slave bus
);
   import dds_adc_pkg::*;

   state_t                  state;
   logic        [LEN_W-1:0] len;
   logic        [LEN_W-1:0] issued;
   logic        [LEN_W-1:0] retired;
   logic                    phase;
   logic signed [31:0]      cos_q;
   logic signed [11:0]      adc_q;
   tag_t                    tag_pipe [MUL_LAT];
   tag_t                    tag_in;
   tag_t                    tag_out;
   logic                    accept;
   logic                    go;
   logic                    pipe_empty;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] i_acc;
   logic signed [ACC_W-1:0] q_acc;
   logic                    i_sat;
   logic                    q_sat;

   assign bus.in_ready = (state == RUN) && !phase && (issued < len);
   assign bus.busy     = (state != IDLE);
   assign accept       = bus.in_valid && bus.in_ready;
   assign go           = (state == IDLE) && bus.start && !bus.abort;
   assign tag_out      = tag_pipe[MUL_LAT-1];
   assign prod_ext     = {{(ACC_W-32){bus.mul_p[31]}}, bus.mul_p};

   // Phase 1 re-issues the latched sample against cosine; idle slots present zeros
   always_comb begin
      bus.mul_a   = '0;
      bus.mul_y   = '0;
      tag_in.vld  = accept || phase;
      tag_in.is_q = phase;
      if (phase) begin
         bus.mul_a = cos_q;
         bus.mul_y = adc_q;
      end else if (accept) begin
         bus.mul_a = bus.dds_sin;
         bus.mul_y = bus.adc;
      end
   end

   always_comb begin
      pipe_empty = 1'b1;
      for (int k = 0; k < MUL_LAT; k++) begin
         if (tag_pipe[k].vld) pipe_empty = 1'b0;
      end
   end

   sat_acc #(.W(ACC_W)) u_i_acc (
      .clk (clk),
      .rst (rst),
      .clr (go),
      .en  (tag_out.vld && !tag_out.is_q && !bus.abort),
      .din (prod_ext),
      .acc (i_acc),
      .sat (i_sat)
   );

   sat_acc #(.W(ACC_W)) u_q_acc (
      .clk (clk),
      .rst (rst),
      .clr (go),
      .en  (tag_out.vld && tag_out.is_q && !bus.abort),
      .din (prod_ext),
      .acc (q_acc),
      .sat (q_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         len           <= '0;
         issued        <= '0;
         retired       <= '0;
         phase         <= 1'b0;
         cos_q         <= '0;
         adc_q         <= '0;
         bus.out_valid <= 1'b0;
         bus.i_sum     <= '0;
         bus.q_sum     <= '0;
         bus.ovf       <= 1'b0;
         for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         phase         <= accept;
         tag_pipe[0]   <= tag_in;
         for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
         if (accept) begin
            cos_q  <= bus.dds_cos;
            adc_q  <= bus.adc;
            issued <= issued + 1'b1;
         end
         if (tag_out.vld && tag_out.is_q) retired <= retired + 1'b1;

         // Abort drops everything in flight but leaves the last reported result alone
         if (bus.abort) begin
            state <= IDLE;
            phase <= 1'b0;
            for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  state   <= RUN;
                  len     <= (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;
                  issued  <= '0;
                  retired <= '0;
               end
               RUN: if (issued == len && !phase) state <= DRAIN;
               DRAIN: if (retired == len && pipe_empty) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.i_sum     <= i_acc;
                  bus.q_sum     <= q_acc;
                  bus.ovf       <= i_sat | q_sat;
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
